// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t       : controller states (IDLE, CALC, FINISH)
//   num_steps()   : number of CALC cycles for a given operand width and step size
//   step_divides(): parameter legality test used at elaboration
package multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int num_steps(input int bit_w, input int step_w);
    return bit_w / step_w;
  endfunction

  function automatic bit step_divides(input int bit_w, input int step_w);
    return (bit_w >= 2) && (step_w > 0) && ((bit_w % step_w) == 0);
  endfunction

endpackage

// File: rtl/multiplier_step.sv
// One shift-add step: next accumulator = acc + mcand * chunk, modulo 2^(2*BIT).
//   mcand_i  [2*BIT-1:0] : shifted multiplicand register
//   chunk_i  [STEP-1:0]  : low STEP bits of the multiplier register
//   acc_i    [2*BIT-1:0] : current accumulator
//   acc_o    [2*BIT-1:0] : next accumulator
module multiplier_step #(
  parameter int BIT  = 16,
  parameter int STEP = 1
) (
  input  logic [2*BIT-1:0] mcand_i,
  input  logic [STEP-1:0]  chunk_i,
  input  logic [2*BIT-1:0] acc_i,
  output logic [2*BIT-1:0] acc_o
);

  logic [2*BIT-1:0] chunk_ext;
  logic [2*BIT-1:0] partial;

  always_comb begin
    chunk_ext = {{(2*BIT-STEP){1'b0}}, chunk_i};
    partial   = mcand_i * chunk_ext;
    acc_o     = acc_i + partial;
  end

endmodule

// File: rtl/multiplier_sequential_parameterized.sv
// Iterative shift-add multiplier retiring STEP multiplier bits per cycle.
// Signed operands are converted to magnitudes on entry and the sign is
// re-applied to the full-width result in FINISH.
//   clk, rst            : clock (rising edge), async active-high reset
//   start               : request, sampled only in IDLE
//   signed_mode         : 1 = two's-complement operands, sampled with start
//   multiplicand        : operand A, sampled with start
//   multiplier          : operand B, sampled with start
//   busy                : high while an operation is in flight
//   done                : one-cycle pulse when product updates
//   product             : last completed result, held until next done
import multiplier_pkg::*;

module multiplier_sequential_parameterized #(
  parameter int BIT  = 16,
  parameter int STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [BIT-1:0]   multiplicand,
  input  logic [BIT-1:0]   multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*BIT-1:0] product
);

  if (!step_divides(BIT, STEP)) begin : g_param_check
    $error("multiplier_sequential_parameterized: BIT must be >= 2 and divisible by STEP");
  end

  localparam int N  = num_steps(BIT, STEP);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_q;
  logic [2*BIT-1:0] mcand_q;
  logic [BIT-1:0]   mplier_q;
  logic [2*BIT-1:0] acc_q;
  logic [2*BIT-1:0] acc_d;
  logic [CW-1:0]    count_q;
  logic             neg_q;

  logic [BIT-1:0]   a_mag;
  logic [BIT-1:0]   b_mag;
  logic             neg_d;

  // Magnitude of the most negative value still fits unsigned in BIT bits.
  always_comb begin
    a_mag = (signed_mode && multiplicand[BIT-1]) ? -multiplicand : multiplicand;
    b_mag = (signed_mode && multiplier[BIT-1])   ? -multiplier   : multiplier;
    neg_d = signed_mode & (multiplicand[BIT-1] ^ multiplier[BIT-1]);
  end

  multiplier_step #(
    .BIT  (BIT),
    .STEP (STEP)
  ) u_step (
    .mcand_i (mcand_q),
    .chunk_i (mplier_q[STEP-1:0]),
    .acc_i   (acc_q),
    .acc_o   (acc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= {{BIT{1'b0}}, a_mag};
            mplier_q <= b_mag;
            neg_q    <= neg_d;
            acc_q    <= '0;
            count_q  <= '0;
            busy     <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << STEP;
          mplier_q <= mplier_q >> STEP;
          count_q  <= count_q + 1'b1;
          if (count_q == LAST) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          product <= neg_q ? -acc_q : acc_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
